// File: rtl/hazard_scoreboard.sv
// Decode-side hazard controller: per-register pending-write scoreboard with RAW/saturation
// stalls, taken-branch flush sequencing and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              kill_valid,
  input  logic [4:0]        kill_rd,
  input  logic              branch_taken,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              issue_fire,
  output logic              busy,
  output logic              err_underflow,
  output logic [PERF_W-1:0] stall_count
);

  localparam int NREG   = 32;
  localparam int FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]         CNT_MAX   = {CNT_W{1'b1}};
  localparam logic signed [CNT_W+1:0]  CNT_MAX_S = $signed({2'b00, CNT_MAX});
  localparam logic signed [CNT_W+1:0]  ONE_S     = 1;
  // The branch cycle itself is the first flush cycle, so FLUSH only covers the remainder.
  localparam logic [FCNT_W-1:0]        FCNT_LOAD = FCNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic signed [CNT_W+1:0] v);
    if (v[CNT_W+1]) return '0;
    if (v > CNT_MAX_S) return CNT_MAX;
    return v[CNT_W-1:0];
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  logic [CNT_W-1:0]  cnt     [NREG];
  logic [CNT_W-1:0]  cnt_nxt [NREG];
  logic              underflow;
  logic              busy_nxt;
  state_t            state, state_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic              rs1_pend, rs2_pend, hazard, sat, hold, flush_act;

  assign rs1_pend  = id_use_rs1 && (id_rs1 != 5'd0) && (cnt[id_rs1] != '0);
  assign rs2_pend  = id_use_rs2 && (id_rs2 != 5'd0) && (cnt[id_rs2] != '0);
  assign hazard    = id_valid && (rs1_pend || rs2_pend);
  assign sat       = id_valid && id_reg_write && (id_rd != 5'd0) && (cnt[id_rd] == CNT_MAX);
  assign hold      = hazard || sat;
  assign flush_act = (state == FLUSH) || branch_taken;

  assign stall_id    = !reset && hold && !flush_act;
  assign stall_if    = stall_id;
  assign flush_if_id = !reset && flush_act;
  assign flush_id_ex = flush_if_id;
  assign issue_fire  = !reset && id_valid && !hold && !flush_act;

  // Net per-register update; all three sources may land on the same register.
  always_comb begin : cnt_update
    logic signed [CNT_W+1:0] v;
    v         = '0;
    underflow = 1'b0;
    busy_nxt  = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      v = $signed({2'b00, cnt[r]});
      if (r != 0) begin
        if (issue_fire && id_reg_write && (id_rd == 5'(r))) v = v + ONE_S;
        if (wb_valid && (wb_rd == 5'(r)))                   v = v - ONE_S;
        if (kill_valid && (kill_rd == 5'(r)))               v = v - ONE_S;
      end
      if (v[CNT_W+1]) underflow = 1'b1;
      cnt_nxt[r] = clamp_cnt(v);
      busy_nxt   = busy_nxt || (cnt_nxt[r] != '0);
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    if (branch_taken) begin
      state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      fcnt_nxt  = FCNT_LOAD;
    end else begin
      case (state)
        RUN:     if (hold) state_nxt = STALL;
        STALL:   if (!hold) state_nxt = RUN;
        FLUSH: begin
          if (fcnt == '0) state_nxt = RUN;
          else            fcnt_nxt  = fcnt - FCNT_W'(1);
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      state         <= RUN;
      fcnt          <= '0;
      busy          <= 1'b0;
      err_underflow <= 1'b0;
      stall_count   <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      state         <= state_nxt;
      fcnt          <= fcnt_nxt;
      busy          <= busy_nxt;
      err_underflow <= err_underflow || underflow;
      if (stall_id) stall_count <= sat_inc(stall_count);
    end
  end

endmodule
